rs_ldst_issue_ctrl: RTL

RS_LDST_ISSUE_CTRL -- requirements
Module: rs_ldst_issue_ctrl

---
 rtl/rs_ldst_issue_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/rs_ldst_issue_ctrl.sv
// rs_ldst_issue_ctrl
// Allocation and issue control for an in-order load/store reservation station.
// The entries form a circular FIFO: dispatch writes at tail, issue reads at
// head, so memory operations leave the station strictly in program order.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   i_dp_req1/i_dp_req2  dispatch slots 1/2 carry a load/store
//   o_alloc_ok           room for every requested slot this cycle
//   o_wr_en              per-entry write enable for the allocated entries
//   o_wr_sel1/o_wr_sel2  entry index for slot 1/slot 2 payload muxing
//   i_ent_busy           busy flag of each entry
//   i_ent_vld            entry busy and both operands ready
//   i_lsu_rdy            load/store unit accepts an issue
//   o_rd_en              one-hot issue read enable
//   o_issue_vld          an entry issues this cycle
//   o_issue_sel          index of the issuing entry
//   i_flush              discard every queued entry
//   o_count              number of occupied entries
//   o_order_err          sticky: head entry not busy while the queue is non-empty
module rs_ldst_issue_ctrl #(
  parameter int RS_ENT_NUM = 4,
  parameter int RS_ENT_SEL = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_dp_req1,
  input  logic                  i_dp_req2,
  output logic                  o_alloc_ok,
  output logic [RS_ENT_NUM-1:0] o_wr_en,
  output logic [RS_ENT_SEL-1:0] o_wr_sel1,
  output logic [RS_ENT_SEL-1:0] o_wr_sel2,
  input  logic [RS_ENT_NUM-1:0] i_ent_busy,
  input  logic [RS_ENT_NUM-1:0] i_ent_vld,
  input  logic                  i_lsu_rdy,
  output logic [RS_ENT_NUM-1:0] o_rd_en,
  output logic                  o_issue_vld,
  output logic [RS_ENT_SEL-1:0] o_issue_sel,
  input  logic                  i_flush,
  output logic [RS_ENT_SEL:0]   o_count,
  output logic                  o_order_err
);

  localparam logic [RS_ENT_SEL+1:0] CAPACITY = (RS_ENT_SEL+2)'(RS_ENT_NUM);

  logic [RS_ENT_SEL-1:0] head;
  logic [RS_ENT_SEL-1:0] tail;
  logic [RS_ENT_SEL:0]   count;
  logic                  order_err;

  logic [RS_ENT_SEL-1:0] head_nxt;
  logic [RS_ENT_SEL-1:0] tail_nxt;
  logic [RS_ENT_SEL:0]   count_nxt;
  logic                  order_err_nxt;

  logic [1:0]            nreq;
  logic [1:0]            nalloc;
  logic [RS_ENT_SEL+1:0] need;
  logic                  alloc_ok;
  logic                  issue_vld;
  logic                  not_empty;
  logic [RS_ENT_SEL-1:0] sel1;
  logic [RS_ENT_SEL-1:0] sel2;

  assign not_empty = (count != '0);

  // Allocation check uses the registered count only; an issue in the same
  // cycle does not make its slot available until the next cycle.
  assign nreq     = {1'b0, i_dp_req1} + {1'b0, i_dp_req2};
  assign need     = {1'b0, count} + {{RS_ENT_SEL{1'b0}}, nreq};
  assign alloc_ok = (need <= CAPACITY) && !i_flush;
  assign nalloc   = alloc_ok ? nreq : 2'd0;

  // Slot 2 packs directly behind slot 1 only when slot 1 is used.
  assign sel1 = tail;
  assign sel2 = i_dp_req1 ? tail + RS_ENT_SEL'(1) : tail;

  // Issue only ever looks at head, so a younger ready entry can never pass
  // a head that is still waiting for operands.
  assign issue_vld = not_empty && i_ent_vld[head] && i_lsu_rdy && !i_flush;

  always_comb begin
    o_wr_en = '0;
    if (alloc_ok) begin
      if (i_dp_req1) o_wr_en[sel1] = 1'b1;
      if (i_dp_req2) o_wr_en[sel2] = 1'b1;
    end
  end

  always_comb begin
    o_rd_en = '0;
    if (issue_vld) o_rd_en[head] = 1'b1;
  end

  always_comb begin
    head_nxt      = head + RS_ENT_SEL'(issue_vld);
    tail_nxt      = tail + RS_ENT_SEL'(nalloc);
    count_nxt     = count + (RS_ENT_SEL+1)'(nalloc) - (RS_ENT_SEL+1)'(issue_vld);
    order_err_nxt = order_err | (not_empty && !i_ent_busy[head]);
    if (i_flush) begin
      head_nxt  = '0;
      tail_nxt  = '0;
      count_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      order_err <= 1'b0;
    end else begin
      head      <= head_nxt;
      tail      <= tail_nxt;
      count     <= count_nxt;
      order_err <= order_err_nxt;
    end
  end

  assign o_alloc_ok  = alloc_ok;
  assign o_wr_sel1   = sel1;
  assign o_wr_sel2   = sel2;
  assign o_issue_vld = issue_vld;
  assign o_issue_sel = head;
  assign o_count     = count;
  assign o_order_err = order_err;

endmodule
